// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int WD_W        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: one request/ack handshake with frozen transaction fields.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
) ();

  logic                  m_req;
  logic                  m_we;
  logic [DATA_W/8-1:0]   m_be;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_ack;
  logic [DATA_W-1:0]     m_rdata;

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts un-acked wait cycles and flags the cycle whose edge reaches TIMEOUT.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [WD_W:0] TIMEOUT_V = TIMEOUT[WD_W:0];

  logic [WD_W-1:0] r_count;
  logic [WD_W:0]   w_countInc;

  assign w_countInc = {1'b0, r_count} + {{WD_W{1'b0}}, 1'b1};

  // Expire looks at the value the counter is about to take, so the abort lands on the same edge.
  assign o_expire = i_enable && (w_countInc == TIMEOUT_V);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_countInc[WD_W-1:0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  mem_port_arbiter_if.master  mem,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  arb_state_e            r_state,    w_stateNext;
  gnt_src_e              r_lastGnt,  w_lastGntNext;
  logic                  r_mReq,     w_mReqNext;
  logic                  r_mWe,      w_mWeNext;
  logic [DATA_W/8-1:0]   r_mBe,      w_mBeNext;
  logic [ADDR_W-1:0]     r_mAddr,    w_mAddrNext;
  logic [DATA_W-1:0]     r_mWdata,   w_mWdataNext;
  logic [DATA_W-1:0]     r_iRdata,   w_iRdataNext;
  logic                  r_iRvalid,  w_iRvalidNext;
  logic [DATA_W-1:0]     r_dRdata,   w_dRdataNext;
  logic                  r_dRvalid,  w_dRvalidNext;
  logic                  r_err,      w_errNext;
  logic                  w_wdClear;
  logic                  w_wdEnable;
  logic                  w_wdExpire;

  assign w_wdClear  = (r_state == IDLE) && (i_req || d_req);
  assign w_wdEnable = (r_state != IDLE) && !mem.m_ack;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wdClear),
    .i_enable (w_wdEnable),
    .o_expire (w_wdExpire)
  );

  always_comb begin
    w_stateNext   = r_state;
    w_lastGntNext = r_lastGnt;
    w_mReqNext    = r_mReq;
    w_mWeNext     = r_mWe;
    w_mBeNext     = r_mBe;
    w_mAddrNext   = r_mAddr;
    w_mWdataNext  = r_mWdata;
    w_iRdataNext  = r_iRdata;
    w_iRvalidNext = 1'b0;
    w_dRdataNext  = r_dRdata;
    w_dRvalidNext = 1'b0;
    w_errNext     = 1'b0;

    case (r_state)
      IDLE: begin
        // Data wins a tie unless it also won the previous grant.
        if (d_req && (!i_req || (r_lastGnt == GNT_I))) begin
          w_stateNext   = D_WAIT;
          w_lastGntNext = GNT_D;
          w_mReqNext    = 1'b1;
          w_mWeNext     = d_we;
          w_mBeNext     = d_be;
          w_mAddrNext   = d_addr;
          w_mWdataNext  = d_wdata;
        end else if (i_req) begin
          w_stateNext   = I_WAIT;
          w_lastGntNext = GNT_I;
          w_mReqNext    = 1'b1;
          w_mWeNext     = 1'b0;
          w_mBeNext     = '1;
          w_mAddrNext   = i_addr;
          w_mWdataNext  = '0;
        end
      end

      I_WAIT, D_WAIT: begin
        if (mem.m_ack || w_wdExpire) begin
          w_stateNext = IDLE;
          w_mReqNext  = 1'b0;
          w_errNext   = !mem.m_ack;
          if (r_state == I_WAIT) begin
            w_iRvalidNext = 1'b1;
            w_iRdataNext  = mem.m_ack ? mem.m_rdata : '0;
          end else begin
            w_dRvalidNext = 1'b1;
            w_dRdataNext  = (mem.m_ack && !r_mWe) ? mem.m_rdata : '0;
          end
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_mReqNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_lastGnt <= GNT_I;
      r_mReq    <= 1'b0;
      r_mWe     <= 1'b0;
      r_mBe     <= '0;
      r_mAddr   <= '0;
      r_mWdata  <= '0;
      r_iRdata  <= '0;
      r_iRvalid <= 1'b0;
      r_dRdata  <= '0;
      r_dRvalid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_lastGnt <= w_lastGntNext;
      r_mReq    <= w_mReqNext;
      r_mWe     <= w_mWeNext;
      r_mBe     <= w_mBeNext;
      r_mAddr   <= w_mAddrNext;
      r_mWdata  <= w_mWdataNext;
      r_iRdata  <= w_iRdataNext;
      r_iRvalid <= w_iRvalidNext;
      r_dRdata  <= w_dRdataNext;
      r_dRvalid <= w_dRvalidNext;
      r_err     <= w_errNext;
    end
  end

  assign mem.m_req   = r_mReq;
  assign mem.m_we    = r_mWe;
  assign mem.m_be    = r_mBe;
  assign mem.m_addr  = r_mAddr;
  assign mem.m_wdata = r_mWdata;

  assign i_rdata  = r_iRdata;
  assign i_rvalid = r_iRvalid;
  assign d_rdata  = r_dRdata;
  assign d_rvalid = r_dRvalid;
  assign err      = r_err;

  assign stall_if  = i_req & ~r_iRvalid;
  assign stall_mem = d_req & ~r_dRvalid;

endmodule
